fetch_ctrl: RTL and testbench
=============================

# fetch_ctrl

Sequencing controller for the `transmit` instruction source. On a start pulse it drives the `transmit` sync request and captures the returned instruction words into a small FIFO. It hands the words to the MIPS core over a valid/ready interface. It throttles `transmit` when the FIFO nears full, checks the program length against the last flag, and reports completion and errors.

## Interface
- IWIDTH, 32: instruction width.
- DEPTH, 7: expected program length in words.
- FDEPTH, 4: FIFO entries; power of 2, ≥ 4.
- CW, $clog2(DEPTH+1): width of the word counter.
- f_clk  in  1  clock; all state updates on its rising edge.
- f_rst  in  1  reset; asynchronous, active-low.
- f_i_start  in  1  begin a program load; sampled only in IDLE.
- f_o_syn  out  1  request to `transmit` (drives t_i_syn).
- f_i_instr  in  IWIDTH  word from `transmit` (t_o_instr).
- f_i_ack  in  1  word valid from `transmit` (t_o_ack).
- f_i_last  in  1  final-word flag from `transmit` (t_o_last).
- f_o_instr  out  IWIDTH  FIFO head word to the core.
- f_o_valid  out  1  FIFO non-empty.
- f_i_ready  in  1  core accepts the head word.
- f_o_busy  out  1  state ≠ IDLE.
- f_o_done  out  1  one-cycle pulse at end of load.
- f_o_count  out  CW  words accepted in the current load.
- f_o_err  out  1  sticky error flag; cleared by reset or the next accepted start.

## Operation
- States:
  - IDLE: f_o_syn=0. On f_i_start=1, go to FETCH, clear f_o_count and f_o_err.
  - FETCH: f_o_syn=1 while occupancy ≤ FDEPTH−2. Every cycle with f_i_ack=1 is a push, and f_o_count increments (saturates at DEPTH).
  - Push with f_i_last=1, go to DRAIN. If the count after the push ≠ DEPTH, set f_o_err.
  - Push that brings the count to DEPTH without f_i_last, set f_o_err and go to DRAIN.
  - DRAIN: f_o_syn=0. Any f_i_ack is dropped and sets f_o_err. When the FIFO is empty, go to IDLE and pulse f_o_done for one cycle.
- f_o_syn is a Moore output, decoded from registered state and occupancy only.
- Contract with `transmit`: at most one ack per cycle, and at most one ack after f_o_syn falls. Headroom of one entry covers that skid.
- Pop on f_o_valid & f_i_ready. f_o_instr shows mem[rptr]; it is don't-care when f_o_valid=0.
- Push at full with no simultaneous pop: word dropped, f_o_err set, count not incremented.
- Push and pop in the same cycle (including at full): both occur, and occupancy is unchanged.
- f_i_start outside IDLE is ignored.
- Pointers are log2(FDEPTH) bits and wrap. Occupancy is log2(FDEPTH)+1 bits.

## Timing
- Reset (f_rst=0, asynchronous): state IDLE, pointers and occupancy 0, and all outputs 0 (f_o_syn, f_o_valid, f_o_instr, f_o_busy, f_o_done, f_o_count, f_o_err).
- Reset mid-load aborts immediately. FIFO contents are discarded and no done pulse is produced.
- start→f_o_syn: 1 cycle (state registers at the edge after start).
- ack→f_o_valid: 1 cycle (written at the edge, visible after it).
- f_o_done: asserted in the cycle after the edge that pops the final word (DRAIN with empty FIFO → IDLE). f_o_busy falls in the same cycle.
- A new start is accepted in the cycle after f_o_done at the earliest.

## Structure
- Shared header `fetch_defs.vh`: state encodings (IDLE=2'd0, FETCH=2'd1, DRAIN=2'd2) and the headroom constant (FDEPTH−2).
- Sub-module `sync_fifo` (IWIDTH, FDEPTH): push/pop/full/empty/occupancy, with the same clock and reset.
- fetch_ctrl holds the FSM, counter, error logic and syn decode. Target is about 200 RTL lines total.

## Test plan
- Nominal load, f_i_ready=1, `transmit` DEPTH=7: start pulse → exactly 7 words out in order, f_o_count=7, f_o_err=0, one f_o_done pulse, f_o_busy returns to 0.
- Backpressure, f_i_ready=0 until f_o_syn drops: occupancy peaks ≤ 4 and f_o_err=0. Then set ready=1 → all 7 words drained in order and done pulses.
- Early last after 5 words: f_o_count=5, f_o_err=1, FIFO drains 5 words, then done.
- Overflow: source model that ignores f_o_syn and acks every cycle, with ready=0 → 5th word dropped, f_o_err=1, f_o_count=4.
- Start pulse during FETCH: ignored; count and err are unaffected.
- f_rst=0 for one cycle mid-FETCH: all outputs read 0 before the next clock edge, and a subsequent start performs a clean 7-word load.

Source files
------------

// File: rtl/fetch_ctrl_pkg.sv
// Shared types and constants for the transmit-fetch sequencer and its FIFO.
package fetch_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_DRAIN = 2'd2
  } state_e;

  // One entry of slack absorbs the single ack that may trail a falling syn.
  function automatic int unsigned headroom(input int unsigned fdepth);
    return fdepth - 2;
  endfunction

endpackage

// File: rtl/fetch_ctrl_sync_fifo.sv
// Single-clock FIFO with wrapping pointers; exports its next occupancy so the
// controller can register decodes that depend on it.
module fetch_ctrl_sync_fifo #(
  parameter int unsigned IWIDTH = 32,
  parameter int unsigned FDEPTH = 4,
  localparam int unsigned AW    = $clog2(FDEPTH),
  localparam int unsigned OW    = AW + 1
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              push_i,
  input  logic [IWIDTH-1:0] wdata_i,
  input  logic              pop_i,
  output logic [IWIDTH-1:0] rdata_o,
  output logic              valid_o,
  output logic              push_ok_c,
  output logic [OW-1:0]     occ_nxt_c
);

  logic [IWIDTH-1:0] mem_q [FDEPTH];
  logic [AW-1:0]     wptr_q;
  logic [AW-1:0]     rptr_q;
  logic [OW-1:0]     occ_q;
  logic              do_pop;

  // A push at full only lands when a pop frees the head slot in the same cycle.
  always_comb begin
    do_pop    = pop_i && (occ_q != '0);
    push_ok_c = push_i && ((occ_q != OW'(FDEPTH)) || do_pop);
    occ_nxt_c = occ_q + OW'(push_ok_c) - OW'(do_pop);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wptr_q <= '0;
      rptr_q <= '0;
      occ_q  <= '0;
      for (int i = 0; i < int'(FDEPTH); i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      if (push_ok_c) begin
        mem_q[wptr_q] <= wdata_i;
        wptr_q        <= wptr_q + AW'(1);
      end
      if (do_pop) begin
        rptr_q <= rptr_q + AW'(1);
      end
      occ_q <= occ_nxt_c;
    end
  end

  assign rdata_o = mem_q[rptr_q];
  assign valid_o = (occ_q != '0);

endmodule

// File: rtl/fetch_ctrl.sv
// Sequences a program load from the transmit source into a small FIFO and
// hands words to the core, tracking length and reporting done/error.
module fetch_ctrl
  import fetch_ctrl_pkg::*;
#(
  parameter int unsigned IWIDTH = 32,
  parameter int unsigned DEPTH  = 7,
  parameter int unsigned FDEPTH = 4,
  parameter int unsigned CW     = $clog2(DEPTH + 1)
) (
  input  logic              f_clk,
  input  logic              f_rst,
  input  logic              f_i_start,
  output logic              f_o_syn,
  input  logic [IWIDTH-1:0] f_i_instr,
  input  logic              f_i_ack,
  input  logic              f_i_last,
  output logic [IWIDTH-1:0] f_o_instr,
  output logic              f_o_valid,
  input  logic              f_i_ready,
  output logic              f_o_busy,
  output logic              f_o_done,
  output logic [CW-1:0]     f_o_count,
  output logic              f_o_err
);

  localparam int unsigned OW       = $clog2(FDEPTH) + 1;
  localparam int unsigned HEADROOM = headroom(FDEPTH);

  state_e          state_q, state_d;
  logic [CW-1:0]   count_q, count_d;
  logic            err_q, err_d;
  logic            done_q, done_d;
  logic            syn_q, syn_d;
  logic            busy_q, busy_d;
  logic            fifo_push;
  logic            fifo_pop;
  logic            fifo_valid;
  logic            push_ok;
  logic [OW-1:0]   occ_nxt;

  assign fifo_push = (state_q == ST_FETCH) && f_i_ack;
  assign fifo_pop  = fifo_valid && f_i_ready;

  fetch_ctrl_sync_fifo #(
    .IWIDTH (IWIDTH),
    .FDEPTH (FDEPTH)
  ) u_fifo (
    .clk_i     (f_clk),
    .rst_ni    (f_rst),
    .push_i    (fifo_push),
    .wdata_i   (f_i_instr),
    .pop_i     (fifo_pop),
    .rdata_o   (f_o_instr),
    .valid_o   (fifo_valid),
    .push_ok_c (push_ok),
    .occ_nxt_c (occ_nxt)
  );

  // Next-state, counter and error logic.
  always_comb begin
    state_d = state_q;
    count_d = count_q;
    err_d   = err_q;
    done_d  = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (f_i_start) begin
          state_d = ST_FETCH;
          count_d = '0;
          err_d   = 1'b0;
        end
      end

      ST_FETCH: begin
        if (f_i_ack) begin
          if (push_ok) begin
            if (count_q != CW'(DEPTH)) begin
              count_d = count_q + CW'(1);
            end
          end else begin
            err_d = 1'b1;
          end
          // Last flag ends the load even if the word itself was dropped.
          if (f_i_last) begin
            state_d = ST_DRAIN;
            if (count_d != CW'(DEPTH)) begin
              err_d = 1'b1;
            end
          end else if (push_ok && (count_d == CW'(DEPTH))) begin
            state_d = ST_DRAIN;
            err_d   = 1'b1;
          end
        end
      end

      ST_DRAIN: begin
        if (f_i_ack) begin
          err_d = 1'b1;
        end
        if (occ_nxt == '0) begin
          state_d = ST_IDLE;
          done_d  = 1'b1;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase

    syn_d  = (state_d == ST_FETCH) && (occ_nxt <= OW'(HEADROOM));
    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge f_clk or negedge f_rst) begin
    if (!f_rst) begin
      state_q <= ST_IDLE;
      count_q <= '0;
      err_q   <= 1'b0;
      done_q  <= 1'b0;
      syn_q   <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      err_q   <= err_d;
      done_q  <= done_d;
      syn_q   <= syn_d;
      busy_q  <= busy_d;
    end
  end

  assign f_o_syn   = syn_q;
  assign f_o_valid = fifo_valid;
  assign f_o_busy  = busy_q;
  assign f_o_done  = done_q;
  assign f_o_count = count_q;
  assign f_o_err   = err_q;

endmodule

// File: tb/tb_fetch_ctrl.sv
// Randomized bench for fetch_ctrl against a queue-based model of the load rules.
module tb_fetch_ctrl;

  localparam int unsigned IW     = 32;
  localparam int unsigned DEPTH  = 7;
  localparam int unsigned FDEPTH = 4;
  localparam int unsigned CW     = $clog2(DEPTH + 1);

  logic          f_clk = 1'b0;
  logic          f_rst = 1'b0;
  logic          start = 1'b0;
  logic          ack   = 1'b0;
  logic          last  = 1'b0;
  logic          ready = 1'b0;
  logic [IW-1:0] instr_in = '0;

  logic          f_o_syn;
  logic [IW-1:0] f_o_instr;
  logic          f_o_valid;
  logic          f_o_busy;
  logic          f_o_done;
  logic [CW-1:0] f_o_count;
  logic          f_o_err;

  fetch_ctrl #(.IWIDTH(IW), .DEPTH(DEPTH), .FDEPTH(FDEPTH), .CW(CW)) dut (
    .f_clk     (f_clk),
    .f_rst     (f_rst),
    .f_i_start (start),
    .f_o_syn   (f_o_syn),
    .f_i_instr (instr_in),
    .f_i_ack   (ack),
    .f_i_last  (last),
    .f_o_instr (f_o_instr),
    .f_o_valid (f_o_valid),
    .f_i_ready (ready),
    .f_o_busy  (f_o_busy),
    .f_o_done  (f_o_done),
    .f_o_count (f_o_count),
    .f_o_err   (f_o_err)
  );

  always #5 f_clk = ~f_clk;

  int errors = 0;
  int checks = 0;

  // Reference model: words held, load/drain phase, counters.
  logic [IW-1:0] mq[$];
  bit m_load, m_drain, m_err, m_done;
  int m_count, m_pops, m_dones;

  // Source and consumer behaviour.
  int src_len, src_idx, rmode;
  bit src_ignore, syn_prev, noise, seen_syn, released;
  int ld_pops, ld_dones;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_clear();
    mq.delete();
    m_load = 0; m_drain = 0; m_err = 0; m_done = 0; m_count = 0;
  endtask

  task automatic model_step();
    int sz;
    bit pop, acc, was_drain;
    sz = mq.size();
    pop = (sz > 0) && ready;
    acc = 0;
    was_drain = m_drain;
    m_done = 0;
    if (!m_load && !m_drain) begin
      if (start) begin
        m_load = 1; m_count = 0; m_err = 0;
      end
    end else if (m_load) begin
      if (ack) begin
        acc = (sz < int'(FDEPTH)) || pop;
        if (acc) begin
          if (m_count < int'(DEPTH)) m_count++;
        end else begin
          m_err = 1;
        end
        if (last) begin
          m_load = 0; m_drain = 1;
          if (m_count != int'(DEPTH)) m_err = 1;
        end else if (acc && m_count == int'(DEPTH)) begin
          m_load = 0; m_drain = 1; m_err = 1;
        end
      end
    end else if (ack) begin
      m_err = 1;
    end
    if (pop) begin
      void'(mq.pop_front());
      m_pops++;
    end
    if (acc) mq.push_back(instr_in);
    if (was_drain && mq.size() == 0) begin
      m_drain = 0; m_done = 1; m_dones++;
    end
  endtask

  task automatic compare();
    chk("syn",   64'(f_o_syn),   64'(m_load && (mq.size() <= int'(FDEPTH) - 2)));
    chk("valid", 64'(f_o_valid), 64'(mq.size() != 0));
    if (mq.size() != 0) chk("instr", 64'(f_o_instr), 64'(mq[0]));
    chk("busy",  64'(f_o_busy),  64'(m_load || m_drain));
    chk("done",  64'(f_o_done),  64'(m_done));
    chk("count", 64'(f_o_count), 64'(m_count));
    chk("err",   64'(f_o_err),   64'(m_err));
  endtask

  task automatic step();
    @(posedge f_clk);
    model_step();
    #1;
    compare();
  endtask

  // Decide next-cycle inputs from what the DUT currently shows.
  task automatic drive();
    bit allow;
    if (f_o_syn) seen_syn = 1;
    if (seen_syn && !f_o_syn) released = 1;
    case (rmode)
      0: ready = 1'($urandom_range(0, 1));
      1: ready = 1'b1;
      2: ready = released;
      default: ready = (src_idx >= src_len);
    endcase
    allow = src_ignore || f_o_syn || syn_prev;
    syn_prev = f_o_syn;
    instr_in = $urandom;
    ack = allow && (src_idx < src_len) && (src_ignore || $urandom_range(0, 3) != 0);
    if (ack) begin
      last = (src_idx == src_len - 1);
      src_idx++;
    end else begin
      last = 1'($urandom_range(0, 1));
    end
    start = noise ? ($urandom_range(0, 3) == 0) : 1'b0;
  endtask

  task automatic run_load(input int len, input bit ign, input int rm, input bit nz,
                          input int abort_after);
    int p0, d0;
    bit finished;
    p0 = m_pops; d0 = m_dones;
    src_len = len; src_idx = 0; src_ignore = ign; rmode = rm; noise = nz;
    syn_prev = 0; seen_syn = 0; released = 0;
    start = 1; ack = 0; last = 0; ready = (rm == 1);
    step();
    start = 0;
    finished = 0;
    for (int i = 0; i < 300; i++) begin
      if (abort_after > 0 && i == abort_after) begin
        finished = 1;
        break;
      end
      drive();
      step();
      if (m_done) begin
        finished = 1;
        break;
      end
    end
    if (!finished) begin
      checks++;
      errors++;
      $display("FAIL timeout: load of %0d words never finished", len);
    end
    ack = 0; last = 0; start = 0;
    ld_pops = m_pops - p0;
    ld_dones = m_dones - d0;
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_syn"},   64'(f_o_syn),   64'd0);
    chk({tag, "_valid"}, 64'(f_o_valid), 64'd0);
    chk({tag, "_instr"}, 64'(f_o_instr), 64'd0);
    chk({tag, "_busy"},  64'(f_o_busy),  64'd0);
    chk({tag, "_done"},  64'(f_o_done),  64'd0);
    chk({tag, "_count"}, 64'(f_o_count), 64'd0);
    chk({tag, "_err"},   64'(f_o_err),   64'd0);
  endtask

  task automatic check_end(input string tag, input int cnt, input bit err, input int pops);
    chk({tag, "_count"}, 64'(f_o_count), 64'(cnt));
    chk({tag, "_err"},   64'(f_o_err),   64'(err));
    chk({tag, "_pops"},  64'(ld_pops),   64'(pops));
    chk({tag, "_dones"}, 64'(ld_dones),  64'd1);
    chk({tag, "_busy"},  64'(f_o_busy),  64'd0);
  endtask

  initial begin
    m_pops = 0; m_dones = 0;
    model_clear();
    repeat (2) @(posedge f_clk);
    #1;
    check_zero("reset");
    f_rst = 1'b1;

    run_load(7, 0, 1, 0, 0);
    check_end("nominal", 7, 0, 7);

    run_load(7, 0, 2, 0, 0);
    check_end("backpressure", 7, 0, 7);

    run_load(5, 0, 1, 0, 0);
    check_end("early_last", 5, 1, 5);

    run_load(7, 1, 3, 0, 0);
    check_end("overflow", 4, 1, 4);

    run_load(7, 0, 0, 1, 0);
    check_end("start_noise", 7, 0, 7);

    run_load(9, 0, 0, 0, 0);
    check_end("long_prog", 7, 1, 7);

    // Abort a load with an asynchronous reset while it is fetching.
    run_load(7, 0, 0, 0, 3);
    chk("abort_busy", 64'(f_o_busy), 64'd1);
    f_rst = 1'b0;
    #1;
    check_zero("midreset");
    model_clear();
    ready = 0;
    #1;
    f_rst = 1'b1;

    run_load(7, 0, 1, 0, 0);
    check_end("post_reset", 7, 0, 7);

    for (int n = 0; n < 12; n++) begin
      run_load(int'($urandom_range(3, 9)), 0, int'($urandom_range(0, 2)),
               1'($urandom_range(0, 1)), 0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
